// File: rtl/updown_counter.sv
// General timing/event counter: configurable width, modulo limit and prescale, with
// up/down, load, clear, terminal-count pulse and sticky overflow. Define COUNTER_SATURATE_EN to saturate instead of wrap.
module updown_counter #(
    parameter int WIDTH    = 8,
    parameter int MAX      = 2**WIDTH - 1,
    parameter int PRESCALE = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             clear,
    input  logic             ovf_clr,
    output logic [WIDTH-1:0] value,
    output logic             tc,
    output logic             ovf
);

    localparam logic [WIDTH-1:0] MAXV = WIDTH'(MAX);

    logic             step;
    logic             at_limit;
    logic             hit;
    logic [WIDTH-1:0] step_val;
    logic [WIDTH-1:0] load_clamped;

    // Prescaler only exists when more than one enabled cycle is needed per step
    generate
        if (PRESCALE > 1) begin : g_prescale
            localparam int            PW   = $clog2(PRESCALE);
            localparam logic [PW-1:0] PLIM = PW'(PRESCALE - 1);

            logic [PW-1:0] psc;

            always_ff @(posedge clk) begin
                if (reset || clear || load) begin
                    psc <= '0;
                end else if (en) begin
                    psc <= (psc == PLIM) ? '0 : psc + PW'(1);
                end
            end

            assign step = en && (psc == PLIM);
        end else begin : g_noprescale
            assign step = en;
        end
    endgenerate

    always_comb begin
        at_limit     = up ? (value == MAXV) : (value == '0);
        load_clamped = (load_val > MAXV) ? MAXV : load_val;
        step_val     = up ? value + WIDTH'(1) : value - WIDTH'(1);
        if (at_limit) begin
`ifdef COUNTER_SATURATE_EN
            step_val = value;
`else
            step_val = up ? '0 : MAXV;
`endif
        end
    end

    // A limit step only counts when clear/load are not overriding it
    assign hit = step && at_limit && !clear && !load;

    always_ff @(posedge clk) begin
        if (reset) begin
            value <= '0;
            tc    <= 1'b0;
        end else if (clear) begin
            value <= '0;
            tc    <= 1'b0;
        end else if (load) begin
            value <= load_clamped;
            tc    <= 1'b0;
        end else if (step) begin
            value <= step_val;
            tc    <= at_limit;
        end else begin
            tc    <= 1'b0;
        end
    end

    // Setting wins over a simultaneous ovf_clr so no wrap is ever lost
    always_ff @(posedge clk) begin
        if (reset) begin
            ovf <= 1'b0;
        end else if (hit) begin
            ovf <= 1'b1;
        end else if (ovf_clr) begin
            ovf <= 1'b0;
        end
    end

endmodule

// File: tb/tb_updown_counter.sv
// Directed testbench for updown_counter: several parameterisations share one stimulus
// stream; each test checks the instance it targets against hand-computed values.
module tb_updown_counter;

    logic       clk;
    logic       reset;
    logic       en;
    logic       up;
    logic       load;
    logic [7:0] load_val;
    logic       clear;
    logic       ovf_clr;

    logic [7:0] v8, v9, vp, v99;
    logic       tc8, tc9, tcp, tc99;
    logic       ov8, ov9, ovp, ov99;

    int testsRun    = 0;
    int testsFailed = 0;

    updown_counter #(.WIDTH(8), .MAX(255), .PRESCALE(1)) d8 (
        .clk(clk), .reset(reset), .en(en), .up(up), .load(load), .load_val(load_val),
        .clear(clear), .ovf_clr(ovf_clr), .value(v8), .tc(tc8), .ovf(ov8));

    updown_counter #(.WIDTH(8), .MAX(9), .PRESCALE(1)) d9 (
        .clk(clk), .reset(reset), .en(en), .up(up), .load(load), .load_val(load_val),
        .clear(clear), .ovf_clr(ovf_clr), .value(v9), .tc(tc9), .ovf(ov9));

    updown_counter #(.WIDTH(8), .MAX(255), .PRESCALE(4)) dp4 (
        .clk(clk), .reset(reset), .en(en), .up(up), .load(load), .load_val(load_val),
        .clear(clear), .ovf_clr(ovf_clr), .value(vp), .tc(tcp), .ovf(ovp));

    updown_counter #(.WIDTH(8), .MAX(99), .PRESCALE(1)) d99 (
        .clk(clk), .reset(reset), .en(en), .up(up), .load(load), .load_val(load_val),
        .clear(clear), .ovf_clr(ovf_clr), .value(v99), .tc(tc99), .ovf(ov99));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one cycle of inputs, then wait for the edge and settle just after it
    task automatic applyStimulus(input logic r, input logic e, input logic u, input logic l,
                                 input logic [7:0] lv, input logic c, input logic oc);
        reset    = r;
        en       = e;
        up       = u;
        load     = l;
        load_val = lv;
        clear    = c;
        ovf_clr  = oc;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        testsRun++;
        if (got !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    initial begin
        reset = 1'b1; en = 1'b1; up = 1'b1; load = 1'b0;
        load_val = 8'd0; clear = 1'b0; ovf_clr = 1'b0;

        // Test 1: reset held with en=1
        for (int i = 0; i < 11; i++) begin
            applyStimulus(1, 1, 1, 0, 8'd0, 0, 0);
            checkOutput("t1_value", v8, 0);
            checkOutput("t1_tc", tc8, 0);
            checkOutput("t1_ovf", ov8, 0);
        end
        reset = 1'b0;
        en    = 1'b0;
        #1;
        checkOutput("t1_rel_value", v8, 0);
        checkOutput("t1_rel_tc", tc8, 0);
        checkOutput("t1_rel_ovf", ov8, 0);

`ifndef COUNTER_SATURATE_EN
        // Test 2: full 8-bit wrap
        for (int k = 1; k <= 256; k++) begin
            applyStimulus(0, 1, 1, 0, 8'd0, 0, 0);
            checkOutput("t2_value", v8, k % 256);
            checkOutput("t2_tc", tc8, (k == 256) ? 1 : 0);
            if (k == 255) checkOutput("t2_ovf_pre", ov8, 0);
        end
        checkOutput("t2_ovf_set", ov8, 1);
        applyStimulus(0, 0, 1, 0, 8'd0, 0, 1);
        checkOutput("t2_ovf_clr", ov8, 0);
        checkOutput("t2_hold", v8, 0);

        // Test 3: MAX=9 down-count wrap
        applyStimulus(0, 0, 0, 1, 8'd0, 0, 0);
        checkOutput("t3_load0", v9, 0);
        checkOutput("t3_ovf_pre", ov9, 0);
        applyStimulus(0, 1, 0, 0, 8'd0, 0, 0);
        checkOutput("t3_wrap_value", v9, 9);
        checkOutput("t3_wrap_tc", tc9, 1);
        checkOutput("t3_ovf", ov9, 1);
        applyStimulus(0, 1, 0, 0, 8'd0, 0, 0);
        checkOutput("t3_value8", v9, 8);
        checkOutput("t3_tc_low", tc9, 0);
        applyStimulus(0, 1, 0, 0, 8'd0, 0, 0);
        checkOutput("t3_value7", v9, 7);
`endif

        // Test 4: prescale by 4
        applyStimulus(1, 0, 1, 0, 8'd0, 0, 0);
        for (int i = 0; i < 12; i++) begin
            applyStimulus(0, 1, 1, 0, 8'd0, 0, 0);
            checkOutput("t4_tc", tcp, 0);
        end
        checkOutput("t4_value3", vp, 3);
        for (int i = 0; i < 5; i++) applyStimulus(0, 0, 1, 0, 8'd0, 0, 0);
        checkOutput("t4_hold", vp, 3);
        for (int i = 0; i < 2; i++) applyStimulus(0, 1, 1, 0, 8'd0, 0, 0);
        checkOutput("t4_partial", vp, 3);
        applyStimulus(1, 1, 1, 0, 8'd0, 0, 0);
        checkOutput("t4_reset", vp, 0);
        for (int i = 0; i < 3; i++) applyStimulus(0, 1, 1, 0, 8'd0, 0, 0);
        checkOutput("t4_no_step", vp, 0);
        applyStimulus(0, 1, 1, 0, 8'd0, 0, 0);
        checkOutput("t4_step", vp, 1);

        // Test 5: load clamp, clear priority, load beats step
        applyStimulus(0, 0, 1, 1, 8'd200, 0, 0);
        checkOutput("t5_clamp", v99, 99);
        applyStimulus(0, 0, 1, 1, 8'd200, 1, 0);
        checkOutput("t5_clear_wins", v99, 0);
        applyStimulus(1, 0, 1, 0, 8'd0, 0, 0);
        for (int i = 0; i < 3; i++) applyStimulus(0, 1, 1, 0, 8'd0, 0, 0);
        checkOutput("t5_pre_psc", vp, 0);
        checkOutput("t5_pre_d99", v99, 3);
        applyStimulus(0, 1, 1, 1, 8'd50, 0, 0);
        checkOutput("t5_load_p4", vp, 50);
        checkOutput("t5_load_p4_tc", tcp, 0);
        checkOutput("t5_load_d99", v99, 50);
        checkOutput("t5_load_d99_tc", tc99, 0);
        for (int i = 0; i < 3; i++) applyStimulus(0, 1, 1, 0, 8'd0, 0, 0);
        checkOutput("t5_after_p4", vp, 50);
        checkOutput("t5_after_d99", v99, 53);
        applyStimulus(0, 1, 1, 0, 8'd0, 0, 0);
        checkOutput("t5_step_p4", vp, 51);
        checkOutput("t5_step_d99", v99, 54);
`ifndef COUNTER_SATURATE_EN
        applyStimulus(0, 0, 1, 1, 8'd255, 0, 0);
        checkOutput("t5_clamp255", v99, 99);
        applyStimulus(0, 1, 1, 0, 8'd0, 0, 0);
        checkOutput("t5_wrap99", v99, 0);
        checkOutput("t5_wrap99_tc", tc99, 1);
        checkOutput("t5_wrap99_ovf", ov99, 1);
`endif

`ifdef COUNTER_SATURATE_EN
        // Test 6: saturation at both limits
        applyStimulus(0, 0, 1, 0, 8'd0, 0, 1);
        applyStimulus(0, 0, 1, 1, 8'd255, 0, 0);
        checkOutput("t6_load", v8, 255);
        checkOutput("t6_ovf_pre", ov8, 0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, 1, 1, 0, 8'd0, 0, 0);
            checkOutput("t6_hold_max", v8, 255);
            checkOutput("t6_tc_max", tc8, 1);
        end
        applyStimulus(0, 0, 0, 1, 8'd0, 0, 0);
        checkOutput("t6_load0", v8, 0);
        applyStimulus(0, 1, 0, 0, 8'd0, 0, 0);
        checkOutput("t6_hold_zero", v8, 0);
        checkOutput("t6_tc_zero", tc8, 1);
        checkOutput("t6_ovf", ov8, 1);
        applyStimulus(0, 1, 1, 0, 8'd0, 0, 0);
        checkOutput("t6_step_up", v8, 1);
        checkOutput("t6_tc_low", tc8, 0);
`endif

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
